tone_detect: RTL and testbench
==============================

Name: tone_detect

Overview:
Frequency-to-code decoder for the MPCD tone path. It recovers the 13-bit tone preload from a speaker square wave produced by the numerically controlled divider. That divider holds each half-period for H = 8192 - ITone clocks of Clk4M and holds the line high for silence (ITone = 8191). tone_detect times successive half-periods, confirms them and reports the preload code. It sits on the capture/verification side, e.g. driving a display or a loopback check of the player.

Parameters:
TONE_W, 13, width of the tone code.
PLC, 13'd8191, preload/silence code; also the code reported when silent.
CNT_W, 15, half-period counter width.
TIMEOUT, 16384, clocks without an edge before the line is declared silent.
TOL, 1, maximum |H_new - H_ref| accepted as a matching half-period.

Ports:
Clk4M  in  1  system clock, 4 MHz.
RST_N  in  1  asynchronous active-low reset.
ISpk  in  1  speaker square wave, asynchronous to Clk4M.
OTone  out  13  recovered tone code, 8192 - H.
OLock  out  1  high while successive half-periods agree within TOL.
OSilent  out  1  high when no edge has been seen for TIMEOUT clocks.
OStb  out  1  one-cycle pulse whenever OTone takes a new value.

Behaviour:
Clock and reset:
- One clock, Clk4M. Reset is asynchronous, active-low, on RST_N.
- Reset values: OTone = PLC, OLock = 0, OSilent = 1, OStb = 0, state = S_SILENT, counter = 0.
- The two synchroniser flops reset to 1, matching the divider's idle-high level. No edge is detected at reset release.

Edge detection and timing:
- ISpk passes through a 2-flop synchroniser, then an edge detector. Both rising and falling edges produce a one-cycle pulse.
- Counter: cleared on an edge pulse, otherwise +1 per clock, saturating at TIMEOUT.
- H is the pulse-to-pulse spacing in clocks. A constant tone T must yield H = 8192 - T exactly.
- Valid H range is 1..8192. An edge with H > 8192 (but before timeout) is out of range.

State machine:
- S_SILENT:
  - edge -> S_ARM.
- S_ARM (first edge seen):
  - edge with H valid: H_ref <= H -> S_MEAS.
  - edge with H out of range: restart S_ARM.
  - timeout -> S_SILENT.
- S_MEAS:
  - edge with |H - H_ref| <= TOL: OTone <= 8192 - H, OLock <= 1, OSilent <= 0, OStb pulse -> S_LOCK.
  - edge without a match: H_ref <= H and stay (an out-of-range H instead goes to S_ARM).
  - timeout -> S_SILENT.
- S_LOCK:
  - matching edge: H_ref <= H. If 8192 - H differs from OTone, update OTone and pulse OStb.
  - mismatching edge: OLock <= 0, OTone holds, H_ref <= H -> S_MEAS.
  - timeout -> S_SILENT.

Entering S_SILENT from any state:
- OTone <= PLC, OLock <= 0, OSilent <= 1.
- OStb pulses only if OTone changed.

Latency:
- OTone/OStb are registered and valid on the cycle after the confirming edge pulse.
- The synchroniser adds 2 further cycles from the ISpk transition.

Arithmetic and corner cases:
- Subtraction is 14-bit; the result is truncated to 13 bits (H = 8192 gives 0).
- TOL compare uses the unsigned absolute difference.
- Edge coincident with the counter reaching TIMEOUT: the edge wins; treat it as an out-of-range H.
- RST_N asserted mid-lock: immediate return to reset values. The next lock needs three fresh edges.

Decomposition:
- Shared package/include: TONE_W, PLC, TIMEOUT defaults, state encodings (S_SILENT, S_ARM, S_MEAS, S_LOCK). The divider and this block must share PLC.
- One sub-module: spk_edge_sync (2-flop synchroniser + any-edge pulse, reset value 1). The FSM, counter and compare stay in tone_detect.

Test Plan:
- Reset release with ISpk = 1 held for 20000 clocks -> no OStb; OTone = 8191; OSilent = 1; OLock = 0 throughout.
- Divider model ITone = 4096 (toggle every 4096 clocks) -> after the third edge, OTone = 4096, OLock = 1, OSilent = 0, exactly one OStb; no further OStb while the tone is steady.
- Boundary codes:
  - ITone = 8190 (H = 2) -> OTone = 8190.
  - ITone = 0 (H = 8192) -> OTone = 0, with no timeout.
  - Retune 0 -> 8190 mid-stream -> OLock drops for one half-period, then relocks with one OStb.
- Jitter, TOL = 1:
  - H alternating 1000/1001 -> stays locked; OTone alternates 7192/7191 with an OStb on each change.
  - H alternating 1000/1003 -> OLock = 0, OTone holds its last value.
- Tone stops (line held high) while locked at 1234 -> exactly TIMEOUT clocks after the last edge: OSilent = 1, OTone = 8191, one OStb pulse.
- RST_N pulsed low for 3 clocks while locked at 4096 -> outputs return to reset values immediately; relock to 4096 after three subsequent edges.

Source files
------------

// File: rtl/tone_detect_pkg.sv
// rtl/tone_detect_pkg.sv - shared constants, FSM states and helpers for the tone path
//
// Purpose: single source for the tone-code width, the preload/silence code
// (also used by the divider), timing defaults and state encodings.
// Ports: none (package).
package tone_detect_pkg;

  localparam int TONE_W = 13;
  // One extra bit so a half-period of exactly 8192 clocks is representable.
  localparam int H_W = TONE_W + 1;
  localparam logic [TONE_W-1:0] PLC = 13'd8191;
  localparam int CNT_W = 15;
  localparam int TIMEOUT_DEF = 16384;
  localparam int TOL_DEF = 1;
  localparam int H_MAX = 8192;

  typedef enum logic [1:0] {
    S_SILENT = 2'd0,
    S_ARM    = 2'd1,
    S_MEAS   = 2'd2,
    S_LOCK   = 2'd3
  } state_t;

  // Half-period to tone code; H = 8192 wraps to code 0.
  function automatic logic [TONE_W-1:0] h_to_tone(input logic [H_W-1:0] h);
    return TONE_W'(H_W'(H_MAX) - h);
  endfunction

  function automatic logic [H_W-1:0] abs_diff(input logic [H_W-1:0] a,
                                              input logic [H_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/tone_detect_spk_edge_sync.sv
// rtl/tone_detect_spk_edge_sync.sv - speaker line synchroniser with any-edge pulse
//
// Purpose: brings the asynchronous speaker square wave into the clock domain
// and emits a one-cycle pulse on every rising or falling transition.
// Ports:
//   clk      in   sampling clock
//   rst_n    in   asynchronous active-low reset
//   spk_in   in   asynchronous speaker line
//   spk_edge out  one-cycle pulse per synchronised transition
module spk_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic spk_in,
  output logic spk_edge
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = spk_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // All stages reset high to match the divider's idle level, so releasing
  // reset with the line high produces no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign spk_edge = sync_q ^ prev_q;

endmodule

// File: rtl/tone_detect.sv
// rtl/tone_detect.sv - recovers the tone preload code from the speaker square wave
//
// Purpose: times successive half-periods of the speaker line, confirms two
// agreeing half-periods and reports code = 8192 - H; reports PLC when silent.
// Ports:
//   Clk4M   in   4 MHz system clock
//   RST_N   in   asynchronous active-low reset
//   ISpk    in   speaker square wave (asynchronous)
//   OTone   out  recovered tone code
//   OLock   out  successive half-periods agree within TOL
//   OSilent out  no edge seen for TIMEOUT clocks
//   OStb    out  one-cycle pulse when OTone is loaded
module tone_detect
  import tone_detect_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TOL     = TOL_DEF
) (
  input  logic              Clk4M,
  input  logic              RST_N,
  input  logic              ISpk,
  output logic [TONE_W-1:0] OTone,
  output logic              OLock,
  output logic              OSilent,
  output logic              OStb
);

  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_HMAX = CNT_W'(H_MAX);
  localparam logic [H_W-1:0]   TOL_H    = H_W'(TOL);

  logic              spk_edge;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [H_W-1:0]    href_q, href_d;
  logic [TONE_W-1:0] tone_q, tone_d;
  logic              lock_q, lock_d;
  logic              silent_q, silent_d;
  logic              stb_q, stb_d;

  logic [CNT_W-1:0]  h_full;
  logic [H_W-1:0]    h;
  logic [TONE_W-1:0] h_code;
  logic              h_ok, h_match, timeout;

  spk_edge_sync u_sync (
    .clk      (Clk4M),
    .rst_n    (RST_N),
    .spk_in   (ISpk),
    .spk_edge (spk_edge)
  );

  // The counter is cleared on the edge cycle, so the spacing is count + 1.
  assign h_full  = cnt_q + CNT_W'(1);
  assign h_ok    = (h_full <= CNT_HMAX);
  assign h       = h_full[H_W-1:0];
  assign h_code  = h_to_tone(h);
  assign h_match = h_ok && (abs_diff(h, href_q) <= TOL_H);
  // Fires as the counter steps onto TIMEOUT; a coincident edge wins and is
  // seen as an out-of-range half-period instead.
  assign timeout = !spk_edge && (cnt_q >= CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (spk_edge)              cnt_d = '0;
    else if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_SILENT: if (spk_edge) state_d = S_ARM;
      S_ARM: begin
        if (spk_edge)     state_d = h_ok ? S_MEAS : S_ARM;
        else if (timeout) state_d = S_SILENT;
      end
      S_MEAS, S_LOCK: begin
        if (spk_edge) begin
          if (!h_ok)        state_d = S_ARM;
          else if (h_match) state_d = S_LOCK;
          else              state_d = S_MEAS;
        end else if (timeout) begin
          state_d = S_SILENT;
        end
      end
      default: state_d = S_SILENT;
    endcase
  end

  // Registered outputs and reference half-period
  always_comb begin
    href_d   = href_q;
    tone_d   = tone_q;
    lock_d   = lock_q;
    silent_d = silent_q;
    stb_d    = 1'b0;
    if (state_q != S_SILENT && timeout) begin
      tone_d   = PLC;
      lock_d   = 1'b0;
      silent_d = 1'b1;
      stb_d    = (tone_q != PLC);
    end else if (spk_edge) begin
      unique case (state_q)
        S_ARM: if (h_ok) href_d = h;
        S_MEAS: begin
          if (h_match) begin
            tone_d   = h_code;
            lock_d   = 1'b1;
            silent_d = 1'b0;
            stb_d    = 1'b1;
          end else if (h_ok) begin
            href_d = h;
          end
        end
        S_LOCK: begin
          if (h_match) begin
            href_d = h;
            if (h_code != tone_q) begin
              tone_d = h_code;
              stb_d  = 1'b1;
            end
          end else begin
            lock_d = 1'b0;
            if (h_ok) href_d = h;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk4M or negedge RST_N) begin
    if (!RST_N) state_q <= S_SILENT;
    else        state_q <= state_d;
  end

  always_ff @(posedge Clk4M or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q    <= '0;
      href_q   <= '0;
      tone_q   <= PLC;
      lock_q   <= 1'b0;
      silent_q <= 1'b1;
      stb_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      href_q   <= href_d;
      tone_q   <= tone_d;
      lock_q   <= lock_d;
      silent_q <= silent_d;
      stb_q    <= stb_d;
    end
  end

  assign OTone   = tone_q;
  assign OLock   = lock_q;
  assign OSilent = silent_q;
  assign OStb    = stb_q;

endmodule

// File: tb/tb_tone_detect.sv
// tb/tb_tone_detect.sv - directed self-checking bench for tone_detect
module tb_tone_detect;

  localparam int TIMEOUT = 16384;

  logic        Clk4M = 1'b0;
  logic        RST_N;
  logic        ISpk;
  logic [12:0] OTone;
  logic        OLock;
  logic        OSilent;
  logic        OStb;

  int n_checks = 0;
  int n_fail   = 0;
  int stb_cnt  = 0;
  int since    = 0;

  tone_detect dut (
    .Clk4M   (Clk4M),
    .RST_N   (RST_N),
    .ISpk    (ISpk),
    .OTone   (OTone),
    .OLock   (OLock),
    .OSilent (OSilent),
    .OStb    (OStb)
  );

  always #125 Clk4M = ~Clk4M;

  always @(negedge Clk4M) if (OStb === 1'b1) stb_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) begin
      @(negedge Clk4M);
      #1;
    end
    since += n;
  endtask

  // Toggle the line h clocks after the previous toggle (divider model).
  task automatic toggle_at(input int h);
    if (h > since) clk_wait(h - since);
    ISpk  = ~ISpk;
    since = 0;
  endtask

  initial begin
    int s0;
    int viol;
    RST_N = 1'b0;
    ISpk  = 1'b1;
    clk_wait(3);
    chk("rst_tone", OTone, 8191);
    chk("rst_lock", OLock, 0);
    chk("rst_silent", OSilent, 1);
    chk("rst_stb", OStb, 0);
    RST_N = 1'b1;

    viol = 0;
    repeat (20000) begin
      clk_wait(1);
      if (OTone !== 13'd8191 || OSilent !== 1'b1 || OLock !== 1'b0) viol++;
    end
    chk("idle_viol", viol, 0);
    chk("idle_stb", stb_cnt, 0);

    // Tone 4096
    s0 = stb_cnt;
    toggle_at(0);
    clk_wait(4);
    chk("arm_silent", OSilent, 1);
    toggle_at(4096);
    clk_wait(4);
    chk("meas_lock", OLock, 0);
    chk("meas_tone", OTone, 8191);
    toggle_at(4096);
    clk_wait(4);
    chk("l4096_tone", OTone, 4096);
    chk("l4096_lock", OLock, 1);
    chk("l4096_silent", OSilent, 0);
    chk("l4096_stb", stb_cnt - s0, 1);

    // Reset pulse mid-lock
    clk_wait(100);
    RST_N = 1'b0;
    ISpk  = 1'b1;
    #1;
    chk("mrst_tone", OTone, 8191);
    chk("mrst_lock", OLock, 0);
    chk("mrst_silent", OSilent, 1);
    chk("mrst_stb", OStb, 0);
    clk_wait(3);
    RST_N = 1'b1;
    s0 = stb_cnt;
    clk_wait(5);
    chk("rel_silent", OSilent, 1);
    toggle_at(0);
    toggle_at(4096);
    clk_wait(4);
    chk("relock_early", OLock, 0);
    toggle_at(4096);
    clk_wait(4);
    chk("relock_tone", OTone, 4096);
    chk("relock_lock", OLock, 1);
    chk("relock_stb", stb_cnt - s0, 1);
    toggle_at(4096);
    clk_wait(4);
    chk("steady_lock", OLock, 1);
    chk("steady_stb", stb_cnt - s0, 1);

    // ITone = 0 (H = 8192)
    toggle_at(8192);
    clk_wait(4);
    chk("h8192_drop", OLock, 0);
    chk("h8192_hold", OTone, 4096);
    s0 = stb_cnt;
    toggle_at(8192);
    // Retune to 8190 (H = 2) right after locking at 0
    toggle_at(2);
    clk_wait(1);
    chk("t0_tone", OTone, 0);
    chk("t0_lock", OLock, 1);
    chk("t0_silent", OSilent, 0);
    chk("t0_stb", OStb, 1);
    toggle_at(2);
    chk("rt_lock_n4", OLock, 1);
    clk_wait(1);
    chk("rt_drop", OLock, 0);
    chk("rt_hold", OTone, 0);
    clk_wait(2);
    chk("rt_tone", OTone, 8190);
    chk("rt_lock", OLock, 1);
    chk("rt_stb", OStb, 1);
    chk("rt_stb_cnt", stb_cnt - s0, 2);

    // Jitter 1000/1001
    s0 = stb_cnt;
    toggle_at(1000);
    clk_wait(4);
    chk("j1_lock", OLock, 0);
    chk("j1_tone", OTone, 8190);
    toggle_at(1001);
    clk_wait(4);
    chk("j2_tone", OTone, 7191);
    chk("j2_lock", OLock, 1);
    toggle_at(1000);
    clk_wait(4);
    chk("j3_tone", OTone, 7192);
    toggle_at(1001);
    clk_wait(4);
    chk("j4_tone", OTone, 7191);
    chk("j4_lock", OLock, 1);
    chk("j_stb", stb_cnt - s0, 3);

    // Jitter 1000/1003
    s0 = stb_cnt;
    toggle_at(1003);
    clk_wait(4);
    chk("w1_lock", OLock, 0);
    chk("w1_tone", OTone, 7191);
    toggle_at(1000);
    clk_wait(4);
    chk("w2_lock", OLock, 0);
    chk("w2_tone", OTone, 7191);
    chk("w_stb", stb_cnt - s0, 0);

    // Lock at 1234 (H = 6958), then line held high
    s0 = stb_cnt;
    toggle_at(6958);
    toggle_at(6958);
    clk_wait(4);
    chk("l1234_tone", OTone, 1234);
    chk("l1234_lock", OLock, 1);
    chk("l1234_stb", stb_cnt - s0, 1);
    chk("l1234_line", ISpk, 1);
    s0 = stb_cnt;
    clk_wait(TIMEOUT + 2 - since);
    chk("to_early_silent", OSilent, 0);
    chk("to_early_tone", OTone, 1234);
    clk_wait(1);
    chk("to_silent", OSilent, 1);
    chk("to_tone", OTone, 8191);
    chk("to_lock", OLock, 0);
    chk("to_stb", OStb, 1);
    clk_wait(1);
    chk("to_stb_end", OStb, 0);
    chk("to_stb_cnt", stb_cnt - s0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
